// File: rtl/oled_layer_compositor_pkg.sv
// Shared types and constants for the OLED layer compositor.
//   - field-select codes for the configuration port
//   - ctrl-word bit positions
//   - layer_t: one rectangle layer (geometry, colour, control)
//   - default panel dimensions
package oled_pkg;

  localparam int unsigned OLED_WIDTH  = 96;
  localparam int unsigned OLED_HEIGHT = 64;

  localparam logic [2:0] FLD_X0    = 3'd0;
  localparam logic [2:0] FLD_Y0    = 3'd1;
  localparam logic [2:0] FLD_X1    = 3'd2;
  localparam logic [2:0] FLD_Y1    = 3'd3;
  localparam logic [2:0] FLD_COLOR = 3'd4;
  localparam logic [2:0] FLD_CTRL  = 3'd5;

  localparam int unsigned CTRL_ENABLE  = 0;
  localparam int unsigned CTRL_OUTLINE = 1;
  localparam int unsigned CTRL_BLINK   = 2;

  typedef struct packed {
    logic [6:0]  x0;
    logic [6:0]  y0;
    logic [6:0]  x1;
    logic [6:0]  y1;
    logic [15:0] color;
    logic        blink;
    logic        outline;
    logic        enable;
  } layer_t;

endpackage

// File: rtl/oled_layer_compositor_if.sv
// Configuration write port of the OLED layer compositor.
//   cfg_we    : write strobe
//   cfg_layer : target layer
//   cfg_field : field select (see FLD_* in oled_pkg)
//   cfg_wdata : write data, truncated to the field width
// master drives the port (control logic), slave receives it (compositor).
interface oled_layer_compositor_if #(
  parameter int unsigned NUM_LAYERS = 4
) ();
  localparam int unsigned LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic               cfg_we;
  logic [LAYER_W-1:0] cfg_layer;
  logic [2:0]         cfg_field;
  logic [15:0]        cfg_wdata;

  modport master (output cfg_we, output cfg_layer, output cfg_field, output cfg_wdata);
  modport slave  (input  cfg_we, input  cfg_layer, input  cfg_field, input  cfg_wdata);
endinterface

// File: rtl/oled_layer_compositor_hit.sv
// Combinational hit test for one rectangle layer.
//   x_i, y_i    : pixel coordinate
//   layer_i     : active layer configuration
//   blink_on_i  : high during the visible half of the blink period
//   hit_o       : layer covers this pixel
module layer_hit
  import oled_pkg::*;
(
  input  logic [6:0] x_i,
  input  logic [6:0] y_i,
  input  layer_t     layer_i,
  input  logic       blink_on_i,
  output logic       hit_o
);
  logic in_x, in_y, on_edge;

  // Inverted bounds (x0 > x1 or y0 > y1) make in_x/in_y unsatisfiable, so such
  // a layer never hits.
  always_comb begin
    in_x    = (x_i >= layer_i.x0) && (x_i <= layer_i.x1);
    in_y    = (y_i >= layer_i.y0) && (y_i <= layer_i.y1);
    on_edge = (x_i == layer_i.x0) || (x_i == layer_i.x1) ||
              (y_i == layer_i.y0) || (y_i == layer_i.y1);
    hit_o   = layer_i.enable && in_x && in_y &&
              (!layer_i.outline || on_edge) &&
              (!layer_i.blink || blink_on_i);
  end
endmodule

// File: rtl/oled_layer_compositor.sv
// Composites NUM_LAYERS rectangles over BG_COLOR for the Oled_Display driver.
//   clock, reset   : pixel clock, synchronous active-high reset
//   frame_begin    : start-of-frame pulse; commits shadow config to active
//   pixel_index    : linear pixel address from the display driver
//   cfg            : configuration write port (slave)
//   pixel_data     : composited colour, 3 cycles after pixel_index
//   commit_pending : shadow config awaits the next frame_begin
//   frame_count    : frames since reset, wrapping
module oled_layer_compositor
  import oled_pkg::*;
#(
  parameter int unsigned         WIDTH      = OLED_WIDTH,
  parameter int unsigned         HEIGHT     = OLED_HEIGHT,
  parameter int unsigned         NUM_LAYERS = 4,
  parameter int unsigned         COLOR_W    = 16,
  parameter logic [COLOR_W-1:0]  BG_COLOR   = '0,
  parameter int unsigned         BLINK_LOG2 = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   frame_begin,
  input  logic [12:0]            pixel_index,
  oled_layer_compositor_if.slave cfg,
  output logic [COLOR_W-1:0]     pixel_data,
  output logic                   commit_pending,
  output logic [7:0]             frame_count
);
  layer_t shadow_q [NUM_LAYERS];
  layer_t shadow_d [NUM_LAYERS];
  layer_t active_q [NUM_LAYERS];

  logic                  wr_ok;
  logic                  pending_d, pending_q;
  logic [7:0]            fc_q;
  logic [6:0]            x_q, y_q;
  logic                  v1_q, v2_q;
  logic                  blink_on;
  logic [NUM_LAYERS-1:0] hit_d, hit_q;
  logic [COLOR_W-1:0]    pix_d, pix_q;

  // Shadow write decode and commit bookkeeping.
  always_comb begin
    wr_ok    = cfg.cfg_we && (int'(cfg.cfg_layer) < int'(NUM_LAYERS)) &&
               (cfg.cfg_field <= FLD_CTRL);
    shadow_d = shadow_q;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      if (wr_ok && int'(cfg.cfg_layer) == i) begin
        case (cfg.cfg_field)
          FLD_X0:    shadow_d[i].x0    = cfg.cfg_wdata[6:0];
          FLD_Y0:    shadow_d[i].y0    = cfg.cfg_wdata[6:0];
          FLD_X1:    shadow_d[i].x1    = cfg.cfg_wdata[6:0];
          FLD_Y1:    shadow_d[i].y1    = cfg.cfg_wdata[6:0];
          FLD_COLOR: shadow_d[i].color = cfg.cfg_wdata;
          FLD_CTRL: begin
            shadow_d[i].blink   = cfg.cfg_wdata[CTRL_BLINK];
            shadow_d[i].outline = cfg.cfg_wdata[CTRL_OUTLINE];
            shadow_d[i].enable  = cfg.cfg_wdata[CTRL_ENABLE];
          end
          default: ;
        endcase
      end
    end
    // A write in the commit cycle lands after the copy, so it stays pending.
    pending_d = pending_q;
    if (frame_begin) pending_d = 1'b0;
    if (wr_ok)       pending_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_LAYERS); i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      pending_q <= 1'b0;
      fc_q      <= '0;
    end else begin
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      if (frame_begin) begin
        active_q <= shadow_q;
        fc_q     <= fc_q + 8'd1;
      end
    end
  end

  assign blink_on = (fc_q[BLINK_LOG2] == 1'b0);

  for (genvar g = 0; g < int'(NUM_LAYERS); g++) begin : g_hit
    layer_hit u_hit (
      .x_i        (x_q),
      .y_i        (y_q),
      .layer_i    (active_q[g]),
      .blink_on_i (blink_on),
      .hit_o      (hit_d[g])
    );
  end

  // Final stage: walk from lowest to highest priority so layer 0 wins.
  always_comb begin
    pix_d = BG_COLOR;
    for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
      if (hit_q[i]) pix_d = COLOR_W'(active_q[i].color);
    end
    if (!v2_q) pix_d = BG_COLOR;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q   <= '0;
      y_q   <= '0;
      v1_q  <= 1'b0;
      hit_q <= '0;
      v2_q  <= 1'b0;
      pix_q <= BG_COLOR;
    end else begin
      x_q   <= 7'(pixel_index % 13'(WIDTH));
      y_q   <= 7'(pixel_index / 13'(WIDTH));
      v1_q  <= (pixel_index < 13'(WIDTH * HEIGHT));
      hit_q <= hit_d;
      v2_q  <= v1_q;
      pix_q <= pix_d;
    end
  end

  assign pixel_data     = pix_q;
  assign commit_pending = pending_q;
  assign frame_count    = fc_q;
endmodule

// File: tb/tb_oled_layer_compositor.sv
// Directed bench for oled_layer_compositor (3 layers, 2-frame blink half-period).
module tb_oled_layer_compositor;
  import oled_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_begin;
  logic [12:0] pixel_index;
  logic [15:0] pixel_data;
  logic        commit_pending;
  logic [7:0]  frame_count;

  int errors = 0;
  int checks = 0;
  int fc     = 0;

  oled_layer_compositor_if #(.NUM_LAYERS(3)) cfg_if ();

  oled_layer_compositor #(
    .WIDTH      (96),
    .HEIGHT     (64),
    .NUM_LAYERS (3),
    .COLOR_W    (16),
    .BG_COLOR   (16'h0000),
    .BLINK_LOG2 (1)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .frame_begin    (frame_begin),
    .pixel_index    (pixel_index),
    .cfg            (cfg_if),
    .pixel_data     (pixel_data),
    .commit_pending (commit_pending),
    .frame_count    (frame_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int layer, input logic [2:0] field, input logic [15:0] data);
    cfg_if.cfg_we    = 1'b1;
    cfg_if.cfg_layer = 2'(layer);
    cfg_if.cfg_field = field;
    cfg_if.cfg_wdata = data;
    tick();
    cfg_if.cfg_we    = 1'b0;
  endtask

  task automatic set_layer(input int layer, input int x0, input int y0, input int x1,
                           input int y1, input logic [15:0] color, input logic [2:0] ctrl);
    wr(layer, FLD_X0, 16'(x0));
    wr(layer, FLD_Y0, 16'(y0));
    wr(layer, FLD_X1, 16'(x1));
    wr(layer, FLD_Y1, 16'(y1));
    wr(layer, FLD_COLOR, color);
    wr(layer, FLD_CTRL, {13'd0, ctrl});
  endtask

  task automatic commit();
    frame_begin = 1'b1;
    tick();
    frame_begin = 1'b0;
    fc++;
  endtask

  task automatic pix(input string tag, input int idx, input logic [15:0] exp);
    pixel_index = 13'(idx);
    repeat (3) tick();
    check_eq(tag, 32'(pixel_data), 32'(exp));
  endtask

  initial begin
    reset            = 1'b1;
    frame_begin      = 1'b0;
    pixel_index      = '0;
    cfg_if.cfg_we    = 1'b0;
    cfg_if.cfg_layer = '0;
    cfg_if.cfg_field = '0;
    cfg_if.cfg_wdata = '0;

    // Reset with pixel_index sweeping
    for (int i = 0; i < 2; i++) begin
      pixel_index = 13'(490 + i);
      tick();
    end
    check_eq("rst_pixel", 32'(pixel_data), 32'h0000);
    check_eq("rst_fc", 32'(frame_count), 32'd0);
    check_eq("rst_pending", 32'(commit_pending), 32'd0);
    reset       = 1'b0;
    pixel_index = '0;

    // Single fill
    set_layer(0, 10, 5, 20, 15, 16'hF800, 3'b001);
    check_eq("fill_pending", 32'(commit_pending), 32'd1);
    pix("fill_precommit", 490, 16'h0000);
    pixel_index = '0;
    commit();
    check_eq("fill_commit_pending", 32'(commit_pending), 32'd0);
    check_eq("fill_fc", 32'(frame_count), 32'd1);
    pixel_index = 13'd490;
    repeat (2) tick();
    check_eq("latency_2cyc", 32'(pixel_data), 32'h0000);
    tick();
    check_eq("latency_3cyc", 32'(pixel_data), 32'hF800);
    pix("fill_489", 489, 16'h0000);
    pix("fill_corner", 15 * 96 + 20, 16'hF800);
    pix("fill_past_x1", 15 * 96 + 21, 16'h0000);
    pix("fill_past_y1", 16 * 96 + 20, 16'h0000);

    // Priority and outline
    set_layer(0, 0, 0, 9, 9, 16'h07E0, 3'b011);
    set_layer(1, 0, 0, 9, 9, 16'h001F, 3'b001);
    commit();
    pix("prio_idx0", 0, 16'h07E0);
    pix("prio_interior", 5 * 96 + 5, 16'h001F);
    pix("prio_bottom_edge", 9 * 96 + 5, 16'h07E0);
    pix("prio_outside", 10, 16'h0000);

    // Tear-free commit
    wr(0, FLD_COLOR, 16'hFFFF);
    check_eq("tear_pending", 32'(commit_pending), 32'd1);
    pix("tear_old_color", 0, 16'h07E0);
    commit();
    check_eq("tear_committed", 32'(commit_pending), 32'd0);
    pix("tear_new_color", 0, 16'hFFFF);

    // Write coincident with frame_begin
    frame_begin      = 1'b1;
    cfg_if.cfg_we    = 1'b1;
    cfg_if.cfg_layer = 2'd0;
    cfg_if.cfg_field = FLD_COLOR;
    cfg_if.cfg_wdata = 16'h1234;
    tick();
    frame_begin   = 1'b0;
    cfg_if.cfg_we = 1'b0;
    fc++;
    check_eq("coinc_pending", 32'(commit_pending), 32'd1);
    check_eq("coinc_fc", 32'(frame_count), 32'(fc));
    pix("coinc_not_applied", 0, 16'hFFFF);
    commit();
    check_eq("coinc_cleared", 32'(commit_pending), 32'd0);
    pix("coinc_applied", 0, 16'h1234);

    // Edge cases: invalid index, inverted bounds
    set_layer(2, 0, 0, 127, 127, 16'hABCD, 3'b001);
    wr(1, FLD_X0, 16'd30);
    wr(1, FLD_X1, 16'd20);
    commit();
    pix("idx_6144", 6144, 16'h0000);
    pix("idx_6143", 6143, 16'hABCD);
    pix("inverted_x25", 25, 16'hABCD);
    pix("inverted_interior", 5 * 96 + 5, 16'hABCD);
    pix("outline_corner", 0, 16'h1234);

    // Out-of-range writes are ignored
    wr(3, FLD_COLOR, 16'h0000);
    check_eq("bad_layer_pending", 32'(commit_pending), 32'd0);
    wr(0, 3'd7, 16'h0000);
    check_eq("bad_field7_pending", 32'(commit_pending), 32'd0);
    wr(0, 3'd6, 16'h0000);
    check_eq("bad_field6_pending", 32'(commit_pending), 32'd0);
    commit();
    pix("bad_writes_no_effect", 0, 16'h1234);

    // Blink, half-period 2 frames; L0 fill over L2
    wr(0, FLD_CTRL, 16'h0005);
    commit();
    for (int k = 0; k < 6; k++) begin
      check_eq("blink_fc", 32'(frame_count), 32'(8'(fc)));
      pix("blink_pixel", 5 * 96 + 5, (((fc >> 1) & 1) == 0) ? 16'h1234 : 16'hABCD);
      commit();
    end
    while ((fc % 256) != 255) commit();
    check_eq("fc_255", 32'(frame_count), 32'd255);
    pix("blink_255_hidden", 5 * 96 + 5, 16'hABCD);
    commit();
    check_eq("fc_wrap", 32'(frame_count), 32'd0);
    pix("blink_0_visible", 5 * 96 + 5, 16'h1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/oled_layer_compositor.md
Name: oled_layer_compositor

Overview:
- Parametrised successor to the single-switch OLED pattern generator: composites NUM_LAYERS rectangular layers over a background colour and drives pixel_data for the Oled_Display driver.
- Layer geometry, colour and control are written through a simple register port into shadow registers. Shadow registers commit to active registers only on frame_begin, so updates never tear mid-frame.
- Adds outline mode, frame-counted blinking and a fixed-latency pixel pipeline.
- Sits between Oled_Display (pixel_index/frame_begin in, pixel_data out) and game/UI control logic, in the clk6p25m domain.

Parameters:
- WIDTH, 96, display columns
- HEIGHT, 64, display rows
- NUM_LAYERS, 4, number of rectangle layers; layer 0 has highest priority
- COLOR_W, 16, RGB565 colour width
- BG_COLOR, 16'h0000, colour where no layer hits
- BLINK_LOG2, 4, blink half-period is 2^BLINK_LOG2 frames

Ports:
- clock  in  1  pixel clock (6.25 MHz)
- reset  in  1  synchronous, active-high reset
- frame_begin  in  1  one-cycle pulse from Oled_Display at the start of each frame
- pixel_index  in  13  linear pixel address 0..WIDTH*HEIGHT-1
- pixel_data  out  COLOR_W  composited colour, registered
- cfg_we  in  1  register write strobe
- cfg_layer  in  $clog2(NUM_LAYERS)  target layer
- cfg_field  in  3  0=x0, 1=y0, 2=x1, 3=y1 (inclusive bounds, 7 bits used), 4=color, 5=ctrl {bit2 blink, bit1 outline, bit0 enable}
- cfg_wdata  in  16  write data
- commit_pending  out  1  shadow differs from active; a commit awaits the next frame_begin
- frame_count  out  8  frames since reset, wraps 255->0

Behaviour:
- Reset, synchronous and active-high:
  - all shadow and active layer fields are cleared to 0, so every layer is disabled
  - all pipeline registers are cleared
  - pixel_data=BG_COLOR, commit_pending=0, frame_count=0
  - reset during a frame takes effect on the next edge; the pipeline restarts cleanly
- Config writes:
  - when cfg_we=1, the selected shadow field takes cfg_wdata (truncated to field width) on the next edge, and commit_pending is set to 1
  - if cfg_layer>=NUM_LAYERS or cfg_field>=6, the write is ignored and commit_pending is unchanged
- Commit on frame_begin:
  - the active set is loaded from shadow, commit_pending is cleared, and frame_count increments
  - if cfg_we and frame_begin occur in the same cycle, the commit copies the pre-write shadow; the write lands in shadow and commit_pending stays 1 (new write pending)
- Pipeline: 3 cycles from pixel_index to pixel_data.
  - S1: registers x=pixel_index%WIDTH and y=pixel_index/WIDTH, plus a valid flag (pixel_index<WIDTH*HEIGHT).
  - S2: registers a per-layer hit bit:
    - enable=1, x0<=x<=x1 and y0<=y<=y1
    - if outline=1, additionally x==x0, x==x1, y==y0 or y==y1
    - if blink=1, additionally frame_count[BLINK_LOG2]==0
    - if x0>x1 or y0>y1, the layer never hits
  - S3: pixel_data gets the colour of the lowest-index hit layer; BG_COLOR if there is no hit or S1 flagged the index invalid.
  - Oled_Display holds pixel_index for 16 clocks per pixel, so a 3-cycle latency is within the sampling margin. The block must not stall or use handshakes.
- Active registers change only at the frame_begin edge, so pixels of one frame always use one consistent configuration. Pixels in flight at the frame_begin edge may use the new config.

Decomposition:
- Package oled_pkg holds:
  - field-select constants (FLD_X0..FLD_CTRL) and ctrl bit positions
  - the layer_t struct {x0, y0, x1, y1 [6:0]; color [15:0]; blink, outline, enable}
  - OLED_WIDTH and OLED_HEIGHT defaults
- Sub-module layer_hit: combinational per-layer hit test on (x, y, layer_t, blink_phase), instantiated NUM_LAYERS times in a generate loop.
- Reuse pixel_index_to_xy for S1 only if it is parametrised by WIDTH; otherwise do the conversion inline.

Test Plan:
- Reset: hold reset 2 cycles with pixel_index sweeping -> pixel_data=16'h0000, frame_count=0, commit_pending=0.
- Single fill:
  - stimulus: layer0 x0=10, y0=5, x1=20, y1=15, color=16'hF800, ctrl=3'b001; pulse frame_begin
  - pixel_index=5*96+10=490 -> pixel_data=16'hF800 after 3 cycles
  - pixel_index=489 -> pixel_data=BG_COLOR
- Priority and outline:
  - stimulus: layer0 outline (ctrl=3'b011, color 16'h07E0) and layer1 fill (color 16'h001F), both on rect 0..9 x 0..9; commit
  - index 0 -> 16'h07E0; index 5*96+5 -> 16'h001F
- Tear-free commit:
  - stimulus: write layer0 color=16'hFFFF mid-frame
  - pixel_data keeps the old colour and commit_pending=1 until frame_begin, then the new colour and commit_pending=0
  - a write coincident with frame_begin -> not applied, commit_pending=1
- Blink with BLINK_LOG2=1: layer enabled with blink=1 -> visible for frame_count 0,1, hidden for 2,3, visible for 4; frame_count wraps 255->0.
- Edge cases:
  - pixel_index=6144 -> BG_COLOR
  - layer with x0=30, x1=20 -> never hits
  - cfg_layer=NUM_LAYERS or cfg_field=7 write -> ignored, commit_pending unchanged
